stage_id_fifo: RTL and testbench
================================

Name: stage_id_fifo

Overview:
Parametrised decode-stage front end that replaces the single IF-to-ID register with a DEPTH-entry instruction queue using a valid/ready handshake toward IF. It extracts rs1/rs2/rd from the queue head and generates opcode-aware load-use stalls that ignore x0. On issue, the head moves into a registered ID output slot that feeds register-file read, bypass and branch logic. Flush support handles branch/jump redirects.

Parameters:
ADDR_WIDTH, 64, PC width
INST_WIDTH, 32, instruction width
REG_NUM, 32, architectural register count; index width RW = $clog2(REG_NUM)
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
if_valid  input  1  IF offers {if_pc, if_pc4, if_inst}
if_ready  output  1  queue can accept (= !full)
if_pc  input  ADDR_WIDTH  PC of offered instruction
if_pc4  input  ADDR_WIDTH  PC+4 of offered instruction
if_inst  input  INST_WIDTH  offered instruction word
flush  input  1  redirect; discard queue and ID slot
stall  input  1  downstream stall; hold ID slot
is_load  input  1  EX stage holds a load
load_rd  input  RW  destination register of that load
id_valid  output  1  ID slot holds a live instruction
id_pc  output  ADDR_WIDTH  ID slot PC
id_pc4  output  ADDR_WIDTH  ID slot PC+4
id_inst  output  INST_WIDTH  ID slot instruction
id_rs1  output  RW  id_inst[19:15]
id_rs2  output  RW  id_inst[24:20]
id_rd  output  RW  id_inst[11:7]
load_stall  output  1  hazard bubble inserted this cycle
count  output  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async): read/write pointers, count, id_valid and load_stall go to 0. id_pc, id_pc4 and id_inst go to 0.
- Push: on a clk edge when if_valid && if_ready && !flush. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- if_ready = (count != DEPTH), derived from registered count only. A full queue refuses a push even if a pop occurs in the same cycle.
- Head usage flags, decoded combinationally from the head opcode:
  - reads_rs1: every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - reads_rs2: only OP (0110011), OP-32 (0111011), STORE (0100011) and BRANCH (1100011).
- Hazard = is_load && load_rd != 0 && count != 0 && ((reads_rs1 && rs1 == load_rd) || (reads_rs2 && rs2 == load_rd)).
- ID slot update at each edge, in priority order:
  - flush: id_valid <= 0; pointers and count <= 0. A same-cycle push is dropped.
  - stall: ID slot unchanged; no pop. Push is still allowed.
  - hazard: id_valid <= 0 (bubble); head retained; load_stall = 1 (combinational, gated by !stall and !flush).
  - count != 0: pop the head into the ID slot; id_valid <= 1; rd_ptr++.
  - otherwise: id_valid <= 0.
- Simultaneous push and pop: count unchanged. Pointers wrap independently.
- Latency: an instruction pushed at edge k into an empty queue appears on id_* after edge k+1 (two-cycle minimum from if_valid).
- Data outputs hold their last value while id_valid = 0.

Decomposition:
- stage_id_pkg:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH).
  - functions reads_rs1(opcode) and reads_rs2(opcode).
  - typedef id_entry_t {pc, pc4, inst}.
- Sub-module inst_fifo #(WIDTH, DEPTH): generic synchronous FIFO with push/pop/clear/full/count, reusable for the other pipeline buffers. stage_id_fifo instantiates it with WIDTH = 2*ADDR_WIDTH + INST_WIDTH.

Test Plan:
- Streaming: reset, then push pc 0x0/0x4/0x8 on consecutive edges with stall = 0 -> id_valid 1 for three consecutive cycles starting one edge after the first push; id_pc 0x0, 0x4, 0x8 in order; count never exceeds 1.
- Full: stall = 1 and offer 5 instructions, DEPTH = 4 -> if_ready falls after the 4th push and count = 4. Release stall -> all 5 issue in order with no loss or duplication.
- Load-use: head 0x002081B3 (add x3,x1,x2) with is_load = 1, load_rd = 1 -> load_stall = 1, one bubble, head kept; issues the next cycle once is_load = 0.
  - head 0x00408293 (addi x5,x1,4) with load_rd = 4 -> no stall (I-type does not read rs2).
  - load_rd = 0 against an inst reading x0 -> no stall.
- Flush: 3 entries queued, flush = 1 with if_valid = 1 in the same cycle -> next cycle count = 0 and id_valid = 0; the pushed entry never issues.
- Wrap-around: 3*DEPTH+1 continuous pushes with a random 1-cycle stall every 3rd cycle -> outputs match a scoreboard in order; count matches the reference model.
- Reset mid-operation: assert reset asynchronously (between edges) with count = 3 and id_valid = 1 -> id_valid, count and load_stall read 0 immediately; after deassertion, the first push issues normally.

Source files
------------

// File: rtl/stage_id_pkg.sv
// Shared decode-stage definitions: RV opcodes that steer the load-use hazard
// check, and the default-width queue entry layout.
package stage_id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] inst;
  } id_entry_t;

  function automatic logic reads_rs1(input logic [6:0] opcode);
    return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_OP32) ||
           (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous FIFO with clear; a full FIFO refuses a push even when
// a pop happens in the same cycle, so full_o depends on registered state only.
module inst_fifo #(
  parameter int unsigned WIDTH = 160,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && (count_q != '0) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stage_id_fifo.sv
// Decode-stage front end: IF-facing instruction queue, load-use hazard
// detection on the queue head, and the registered ID output slot.
module stage_id_fifo
  import stage_id_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned RW = $clog2(REG_NUM),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [ADDR_WIDTH-1:0] if_pc4,
  input  logic [INST_WIDTH-1:0] if_inst,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  is_load,
  input  logic [RW-1:0]         load_rd,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc4,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [RW-1:0]         id_rs1,
  output logic [RW-1:0]         id_rs2,
  output logic [RW-1:0]         id_rd,
  output logic                  load_stall,
  output logic [CW-1:0]         count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc4;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t        in_entry, head;
  entry_t        id_entry_q, id_entry_d;
  logic          id_valid_q, id_valid_d;
  logic          fifo_full, nonempty, hazard, pop;
  logic [6:0]    head_opc;
  logic [RW-1:0] head_rs1, head_rs2;

  assign in_entry = '{pc: if_pc, pc4: if_pc4, inst: if_inst};

  inst_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (if_valid),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .clear_i (flush),
    .rdata_o (head),
    .full_o  (fifo_full),
    .count_o (count)
  );

  assign if_ready = !fifo_full;
  assign nonempty = (count != '0);
  assign head_opc = head.inst[6:0];
  assign head_rs1 = head.inst[15 +: RW];
  assign head_rs2 = head.inst[20 +: RW];

  // x0 is never a real dependency, so a load targeting it never stalls.
  assign hazard = is_load && (load_rd != '0) && nonempty &&
                  ((reads_rs1(head_opc) && (head_rs1 == load_rd)) ||
                   (reads_rs2(head_opc) && (head_rs2 == load_rd)));

  assign pop        = !flush && !stall && !hazard && nonempty;
  assign load_stall = hazard && !stall && !flush;

  always_comb begin
    id_valid_d = id_valid_q;
    id_entry_d = id_entry_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_valid_d = id_valid_q;
    end else if (hazard) begin
      id_valid_d = 1'b0;
    end else if (nonempty) begin
      id_valid_d = 1'b1;
      id_entry_d = head;
    end else begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_entry_q <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_entry_q <= id_entry_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_entry_q.pc;
  assign id_pc4   = id_entry_q.pc4;
  assign id_inst  = id_entry_q.inst;
  assign id_rs1   = id_entry_q.inst[15 +: RW];
  assign id_rs2   = id_entry_q.inst[20 +: RW];
  assign id_rd    = id_entry_q.inst[7 +: RW];

endmodule

// File: tb/tb_stage_id_fifo.sv
// Directed bench for stage_id_fifo: per-cycle vector table plus hand-written
// wrap-around (scoreboarded) and asynchronous-reset sequences.
module tb_stage_id_fifo;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] ADDI = 32'h0040_8293;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready, flush, stall, is_load, id_valid, load_stall;
  logic [63:0] if_pc, if_pc4, id_pc, id_pc4;
  logic [31:0] if_inst, id_inst;
  logic [4:0]  load_rd, id_rs1, id_rs2, id_rd;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  stage_id_fifo #(
    .ADDR_WIDTH (64),
    .INST_WIDTH (32),
    .REG_NUM    (32),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .if_inst    (if_inst),
    .flush      (flush),
    .stall      (stall),
    .is_load    (is_load),
    .load_rd    (load_rd),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_inst    (id_inst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .load_stall (load_stall),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        st;
    logic        ld;
    logic [4:0]  lrd;
    logic        fl;
    logic        e_rdy;
    logic        e_lst;
    logic        e_idv;
    logic [63:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                              input logic st, input logic ld, input logic [4:0] lrd,
                              input logic fl, input logic e_rdy, input logic e_lst,
                              input logic e_idv, input logic [63:0] e_pc,
                              input logic [2:0] e_cnt);
    vec_t x;
    x.v = v; x.pc = pc; x.inst = inst; x.st = st; x.ld = ld; x.lrd = lrd; x.fl = fl;
    x.e_rdy = e_rdy; x.e_lst = e_lst; x.e_idv = e_idv; x.e_pc = e_pc; x.e_cnt = e_cnt;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic st, input logic ld, input logic [4:0] lrd, input logic fl);
    if_valid = v; if_pc = pc; if_pc4 = pc + 64'd4; if_inst = inst;
    stall = st; is_load = ld; load_rd = lrd; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] q[$];
    logic        m_idv;
    logic [63:0] m_pc;
    int          sent;
    logic        v, st, rdy;

    reset = 1'b1;
    drive(1'b0, 64'h0, NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    #11;
    chk("reset_id_valid", {63'd0, id_valid}, 64'd0);
    chk("reset_count", {61'd0, count}, 64'd0);
    chk("reset_load_stall", {63'd0, load_stall}, 64'd0);
    chk("reset_if_ready", {63'd0, if_ready}, 64'd1);
    chk("reset_id_pc", id_pc, 64'd0);
    #1 reset = 1'b0;

    // v  pc  inst st ld lrd fl | rdy lst idv id_pc cnt
    add(1, 'h00, NOP,  0, 0, 0, 0, 1, 0, 0, 'h00, 1);
    add(1, 'h04, NOP,  0, 0, 0, 0, 1, 0, 1, 'h00, 1);
    add(1, 'h08, NOP,  0, 0, 0, 0, 1, 0, 1, 'h04, 1);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h08, 0);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 0, 'h08, 0);
    add(1, 'h10, NOP,  1, 0, 0, 0, 1, 0, 0, 'h08, 1);
    add(1, 'h14, NOP,  1, 0, 0, 0, 1, 0, 0, 'h08, 2);
    add(1, 'h18, NOP,  1, 0, 0, 0, 1, 0, 0, 'h08, 3);
    add(1, 'h1C, NOP,  1, 0, 0, 0, 1, 0, 0, 'h08, 4);
    add(1, 'h20, NOP,  1, 0, 0, 0, 0, 0, 0, 'h08, 4);
    add(1, 'h20, NOP,  0, 0, 0, 0, 0, 0, 1, 'h10, 3);
    add(1, 'h20, NOP,  0, 0, 0, 0, 1, 0, 1, 'h14, 3);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h18, 2);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h1C, 1);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h20, 0);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 0, 'h20, 0);
    add(1, 'h30, ADD,  0, 1, 1, 0, 1, 0, 0, 'h20, 1);
    add(0, 'h00, NOP,  0, 1, 1, 0, 1, 1, 0, 'h20, 1);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h30, 0);
    add(1, 'h40, ADDI, 0, 1, 4, 0, 1, 0, 0, 'h30, 1);
    add(0, 'h00, NOP,  0, 1, 4, 0, 1, 0, 1, 'h40, 0);
    add(1, 'h50, NOP,  0, 1, 0, 0, 1, 0, 0, 'h40, 1);
    add(0, 'h00, NOP,  0, 1, 0, 0, 1, 0, 1, 'h50, 0);
    add(1, 'h60, ADD,  0, 1, 1, 0, 1, 0, 0, 'h50, 1);
    add(0, 'h00, NOP,  1, 1, 2, 0, 1, 0, 0, 'h50, 1);
    add(0, 'h00, NOP,  0, 1, 2, 0, 1, 1, 0, 'h50, 1);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 1, 'h60, 0);
    add(1, 'h70, NOP,  1, 0, 0, 0, 1, 0, 1, 'h60, 1);
    add(1, 'h74, NOP,  1, 0, 0, 0, 1, 0, 1, 'h60, 2);
    add(1, 'h78, NOP,  1, 0, 0, 0, 1, 0, 1, 'h60, 3);
    add(1, 'h7C, NOP,  0, 0, 0, 1, 1, 0, 0, 'h60, 0);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 0, 'h60, 0);
    add(0, 'h00, NOP,  0, 0, 0, 0, 1, 0, 0, 'h60, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].st, vecs[i].ld, vecs[i].lrd,
            vecs[i].fl);
      #1;
      chk($sformatf("v%0d_if_ready", i), {63'd0, if_ready}, {63'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_load_stall", i), {63'd0, load_stall}, {63'd0, vecs[i].e_lst});
      tick();
      chk($sformatf("v%0d_id_valid", i), {63'd0, id_valid}, {63'd0, vecs[i].e_idv});
      chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_count", i), {61'd0, count}, {61'd0, vecs[i].e_cnt});
    end

    // ID slot still holds add x3,x1,x2 from pc 0x60.
    chk("fields_inst", {32'd0, id_inst}, {32'd0, ADD});
    chk("fields_pc4", id_pc4, 64'h64);
    chk("fields_rs1", {59'd0, id_rs1}, 64'd1);
    chk("fields_rs2", {59'd0, id_rs2}, 64'd2);
    chk("fields_rd", {59'd0, id_rd}, 64'd3);

    // Wrap-around against a reference queue model.
    m_idv = 1'b0;
    m_pc  = 64'h60;
    sent  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      v   = (sent < 13);
      st  = ((cyc % 3) == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy = (q.size() != 4);
      drive(v, 64'h100 + 64'(4 * sent), NOP, st, 1'b0, 5'd0, 1'b0);
      #1;
      chk($sformatf("wrap%0d_if_ready", cyc), {63'd0, if_ready}, {63'd0, rdy});
      if (!st) begin
        if (q.size() != 0) begin
          m_idv = 1'b1;
          m_pc  = q.pop_front();
        end else begin
          m_idv = 1'b0;
        end
      end
      if (v && rdy) begin
        q.push_back(64'h100 + 64'(4 * sent));
        sent++;
      end
      tick();
      chk($sformatf("wrap%0d_count", cyc), {61'd0, count}, 64'(q.size()));
      chk($sformatf("wrap%0d_id_valid", cyc), {63'd0, id_valid}, {63'd0, m_idv});
      chk($sformatf("wrap%0d_id_pc", cyc), id_pc, m_pc);
    end
    chk("wrap_all_sent", 64'(sent), 64'd13);

    // Asynchronous reset mid-operation with count = 3 and id_valid = 1.
    drive(1'b1, 64'h200, NOP, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 64'h204, NOP, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 64'h208, NOP, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 64'h20C, NOP, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b0, 64'h0, NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("pre_rst_count", {61'd0, count}, 64'd3);
    chk("pre_rst_id_valid", {63'd0, id_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("async_rst_count", {61'd0, count}, 64'd0);
    chk("async_rst_load_stall", {63'd0, load_stall}, 64'd0);
    chk("async_rst_id_pc", id_pc, 64'd0);
    #1 reset = 1'b0;
    drive(1'b1, 64'h300, NOP, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("post_rst_count", {61'd0, count}, 64'd1);
    chk("post_rst_id_valid0", {63'd0, id_valid}, 64'd0);
    drive(1'b0, 64'h0, NOP, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("post_rst_id_valid1", {63'd0, id_valid}, 64'd1);
    chk("post_rst_id_pc", id_pc, 64'h300);
    chk("post_rst_count0", {61'd0, count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
